// File: rtl/lut_cfg_pkg.sv
// Shared types and helpers for the serial LUT configuration loader.
// Frame layout: 16 data bits MSB first, then one even-parity bit.
package lut_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_CHECK  = 2'd2,
    ST_ACTIVE = 2'd3
  } cfg_state_e;

  localparam int FRAME_BITS = 17;
  localparam int PARITY_IDX = 16;
  localparam int CNT_W      = 5;

  // Even parity: data bits plus parity bit must contain an even number of ones.
  function automatic logic parity_ok(input logic [PARITY_IDX-1:0] data, input logic p);
    return ((^data) ^ p) == 1'b0;
  endfunction

endpackage

// File: rtl/lut4_eval.sv
// Registered LUT evaluation: o = init[sel], one cycle after sel is presented.
// Kept generic in K so wider LUT variants can reuse it.
module lut4_eval #(
  parameter int K      = 4,
  parameter int INIT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [INIT_W-1:0] init_i,
  input  logic [K-1:0]      sel_i,
  output logic              o_o
);

  logic o_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_q <= 1'b0;
    end else begin
      o_q <= init_i[sel_i];
    end
  end

  assign o_o = o_q;

endmodule

// File: rtl/lut4_cfg_loader.sv
// Bit-serial INIT loader with parity check and atomic commit, feeding a registered LUT4.
// The active table only changes on a clean frame; partial or bad frames never leak into O.
module lut4_cfg_loader
  import lut_cfg_pkg::*;
#(
  parameter int                K          = 4,
  parameter int                INIT_W     = 16,
  parameter logic [INIT_W-1:0] RESET_INIT = 16'h0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_start,
  input  logic              cfg_valid,
  input  logic              cfg_bit,
  output logic              cfg_ready,
  output logic              cfg_done,
  output logic              cfg_err,
  input  logic [K-1:0]      I,
  output logic              O,
  output logic [INIT_W-1:0] init
);

  if (INIT_W != (1 << K)) begin : g_bad_width
    $error("lut4_cfg_loader: INIT_W must equal 2**K");
  end

  cfg_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [INIT_W-1:0] shadow_q, shadow_d;
  logic [INIT_W-1:0] init_q, init_d;
  logic              par_q, par_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      init_q   <= RESET_INIT;
      par_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      init_q   <= init_d;
      par_q    <= par_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    init_d   = init_q;
    par_d    = par_q;
    done_d   = 1'b0;
    err_d    = err_q;

    // A restart wins over everything, including a bit offered in the same cycle.
    if (cfg_start) begin
      state_d  = ST_LOAD;
      cnt_d    = '0;
      shadow_d = '0;
      err_d    = 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (cfg_valid) begin
            if (cnt_q == CNT_W'(PARITY_IDX)) begin
              par_d   = cfg_bit;
              cnt_d   = CNT_W'(FRAME_BITS);
              state_d = ST_CHECK;
            end else begin
              shadow_d = {shadow_q[INIT_W-2:0], cfg_bit};
              cnt_d    = cnt_q + CNT_W'(1);
            end
          end
        end
        ST_CHECK: begin
          if (parity_ok(shadow_q, par_q)) begin
            init_d  = shadow_q;
            done_d  = 1'b1;
            state_d = ST_ACTIVE;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign cfg_ready = (state_q == ST_LOAD);
  assign cfg_done  = done_q;
  assign cfg_err   = err_q;
  assign init      = init_q;

  lut4_eval #(
    .K      (K),
    .INIT_W (INIT_W)
  ) u_eval (
    .clk    (clk),
    .rst_n  (rst_n),
    .init_i (init_q),
    .sel_i  (I),
    .o_o    (O)
  );

endmodule
